// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared encodings for the multi-cycle main control FSM:
//               opcodes, ALUop values, mux selects and the state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Opcode field values (instr[15:12])
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALUop values; FUNC tells ALU control to decode the instruction FuncCode
  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b0001;
  localparam logic [3:0] ALUOP_FUNC = 4'b1111;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13,
    S_ERROR    = 4'd14
  } state_t;

  // States that stall on mem_ready and are guarded by the wait timer
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Saturating counter of consecutive memory-stall cycles with
//               an expiry flag raised once MAX_WAIT stalls have been seen.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int c_CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_WAIT);

  logic [c_CNT_W-1:0] r_count;

  // Stall counter: clear wins, otherwise count up and hold at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != c_MAX)) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  assign o_expired = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Main control FSM of the multi-cycle processor. Sequences
//               fetch/decode/execute/memory/writeback, drives datapath
//               enables and the ALUop fed to ALU control, and traps a hung
//               memory handshake into a sticky bus-error state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int ALUOP_W  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               halted,
  output logic               bus_error
);

  state_t r_state;
  state_t w_state_next;
  logic   w_expired;
  logic   w_clear;
  logic   w_count_en;
  logic   w_unused_zero;

  // The branch decision is made in the datapath from pc_write_cond & zero
  assign w_unused_zero = zero;

  // Restart the stall count whenever the state changes; count only stalls
  assign w_clear    = (w_state_next != r_state);
  assign w_count_en = is_wait_state(r_state) && !mem_ready;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (reset),
    .i_clear    (w_clear),
    .i_count_en (w_count_en),
    .o_expired  (w_expired)
  );

  // State register; async reset returns straight to START with outputs low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_START;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore output decode (FETCH write enables follow mem_ready)
  always_comb begin
    w_state_next  = r_state;
    ALUop         = ALUOP_W'(ALUOP_ADD);
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    halted        = 1'b0;
    bus_error     = 1'b0;

    case (r_state)
      S_START: begin
        w_state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)      w_state_next = S_DECODE;
        else if (w_expired) w_state_next = S_ERROR;
      end

      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        case (opcode)
          OP_W'(OP_R):    w_state_next = S_EXEC_R;
          OP_W'(OP_ADDI): w_state_next = S_EXEC_I;
          OP_W'(OP_LW):   w_state_next = S_MEM_ADDR;
          OP_W'(OP_SW):   w_state_next = S_MEM_ADDR;
          OP_W'(OP_BEQ):  w_state_next = S_BRANCH;
          OP_W'(OP_J):    w_state_next = S_JUMP;
          OP_W'(OP_HALT): w_state_next = S_HALT;
          default:        w_state_next = S_FETCH;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_REG;
        ALUop        = ALUOP_W'(ALUOP_FUNC);
        w_state_next = S_WB_R;
      end

      S_WB_R: begin
        reg_dst      = 1'b1;
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_state_next = S_WB_I;
      end

      S_WB_I: begin
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_state_next = (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)      w_state_next = S_WB_MEM;
        else if (w_expired) w_state_next = S_ERROR;
      end

      S_WB_MEM: begin
        mem_to_reg   = 1'b1;
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)      w_state_next = S_FETCH;
        else if (w_expired) w_state_next = S_ERROR;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        ALUop         = ALUOP_W'(ALUOP_SUB);
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        w_state_next  = S_FETCH;
      end

      S_JUMP: begin
        pc_write     = 1'b1;
        pc_source    = PCSRC_JUMP;
        w_state_next = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      S_ERROR: begin
        bus_error = 1'b1;
      end

      default: begin
        w_state_next = S_START;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Scoreboard bench for the multi-cycle control FSM. Stimulus
//               walks instruction-level scenarios and queues the expected
//               control word for every cycle; a monitor compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] ALUop;
  logic       alu_src_a, ir_write, pc_write, pc_write_cond, i_or_d;
  logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
  logic       halted, bus_error;
  logic [1:0] alu_src_b, pc_source;

  typedef struct packed {
    logic [3:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       halted;
    logic       bus_error;
  } vec_t;

  vec_t  act;
  vec_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;

  multicycle_control_fsm #(
    .OP_W(4), .ALUOP_W(4), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .ALUop(ALUop), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .halted(halted),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  assign act = {ALUop, alu_src_a, alu_src_b, ir_write, pc_write, pc_write_cond,
                pc_source, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                reg_write, halted, bus_error};

  // Expected control word for each step of an instruction, from the ISA table
  function automatic vec_t v_fetch(input logic rdy);
    vec_t v = '0;
    v.mem_read = 1'b1; v.src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy;
    return v;
  endfunction
  function automatic vec_t v_decode();
    vec_t v = '0; v.src_b = 2'b11; return v;
  endfunction
  function automatic vec_t v_exec_r();
    vec_t v = '0; v.src_a = 1'b1; v.aluop = 4'b1111; return v;
  endfunction
  function automatic vec_t v_alu_imm();
    vec_t v = '0; v.src_a = 1'b1; v.src_b = 2'b10; return v;
  endfunction
  function automatic vec_t v_wb(input logic rd, input logic mdr);
    vec_t v = '0; v.reg_write = 1'b1; v.reg_dst = rd; v.mem_to_reg = mdr; return v;
  endfunction
  function automatic vec_t v_mem(input logic wr);
    vec_t v = '0; v.i_or_d = 1'b1; v.mem_read = ~wr; v.mem_write = wr; return v;
  endfunction
  function automatic vec_t v_branch();
    vec_t v = '0;
    v.src_a = 1'b1; v.aluop = 4'b0001; v.pc_write_cond = 1'b1; v.pc_source = 2'b01;
    return v;
  endfunction
  function automatic vec_t v_jump();
    vec_t v = '0; v.pc_write = 1'b1; v.pc_source = 2'b10; return v;
  endfunction
  function automatic vec_t v_halt();
    vec_t v = '0; v.halted = 1'b1; return v;
  endfunction
  function automatic vec_t v_error();
    vec_t v = '0; v.bus_error = 1'b1; return v;
  endfunction

  // Monitor: one expected control word per cycle, compared mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        vec_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s t=%0t got=%h exp=%h", t, $time, act, e);
        end
      end
    end
  end

  task automatic check_now(input string name, input vec_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, e);
    end
  endtask

  // One clock of stimulus; called and returns at posedge+1
  task automatic cyc(input logic [3:0] opc, input logic rdy, input vec_t e,
                     input string t);
    opcode    = opc;
    mem_ready = rdy;
    zero      = 1'($urandom);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_now("reset_async_zero", '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(4'($urandom), 1'($urandom), '0, "start");
  endtask

  // Memory handshake with a given number of stall cycles; too many -> ERROR
  task automatic wait_phase(input logic [3:0] opc, input int waits,
                            input vec_t busy, input vec_t done,
                            input string t, output bit err);
    err = 1'b0;
    if (waits > MAX_WAIT) begin
      for (int i = 0; i <= MAX_WAIT; i++) cyc(opc, 1'b0, busy, t);
      for (int i = 0; i < 4; i++) cyc(4'($urandom), 1'($urandom), v_error(), "error_sticky");
      err = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) cyc(opc, 1'b0, busy, t);
      cyc(opc, 1'b1, done, t);
    end
  endtask

  task automatic run_instr(input logic [3:0] opc, input int fw, input int mw,
                           input int halt_cycles);
    bit err;
    wait_phase(4'($urandom), fw, v_fetch(1'b0), v_fetch(1'b1), "fetch", err);
    if (err) begin do_reset(); return; end
    cyc(opc, 1'($urandom), v_decode(), "decode");
    case (opc)
      4'b0000: begin
        cyc(opc, 1'($urandom), v_exec_r(), "exec_r");
        cyc(opc, 1'($urandom), v_wb(1'b1, 1'b0), "wb_r");
      end
      4'b0001: begin
        cyc(opc, 1'($urandom), v_alu_imm(), "exec_i");
        cyc(opc, 1'($urandom), v_wb(1'b0, 1'b0), "wb_i");
      end
      4'b0010: begin
        cyc(opc, 1'($urandom), v_alu_imm(), "mem_addr");
        wait_phase(opc, mw, v_mem(1'b0), v_mem(1'b0), "mem_rd", err);
        if (err) begin do_reset(); return; end
        cyc(opc, 1'($urandom), v_wb(1'b0, 1'b1), "wb_mem");
      end
      4'b0011: begin
        cyc(opc, 1'($urandom), v_alu_imm(), "mem_addr");
        wait_phase(opc, mw, v_mem(1'b1), v_mem(1'b1), "mem_wr", err);
        if (err) begin do_reset(); return; end
      end
      4'b0100: cyc(opc, 1'($urandom), v_branch(), "branch");
      4'b0101: cyc(opc, 1'($urandom), v_jump(), "jump");
      4'b1111: begin
        for (int i = 0; i < halt_cycles; i++)
          cyc(4'($urandom), 1'($urandom), v_halt(), "halt");
        do_reset();
      end
      default: ;
    endcase
  endtask

  function automatic int pick_waits();
    int r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(0, 2));
    if (r < 16) return MAX_WAIT;
    if (r < 17) return MAX_WAIT + 1;
    return int'($urandom_range(0, MAX_WAIT));
  endfunction

  initial begin
    bit err;
    do_reset();

    // Reset in the middle of a stalled store
    wait_phase(4'h0, 0, v_fetch(1'b0), v_fetch(1'b1), "fetch", err);
    cyc(4'b0011, 1'b1, v_decode(), "decode");
    cyc(4'b0011, 1'b1, v_alu_imm(), "mem_addr");
    cyc(4'b0011, 1'b0, v_mem(1'b1), "mem_wr");
    check_now("mid_wr_strobe", v_mem(1'b1));
    do_reset();

    // Directed scenarios
    run_instr(4'b0000, 0, 0, 0);             // R-type, zero wait
    run_instr(4'b0010, 0, 3, 0);             // LW with 3 stall cycles
    run_instr(4'b0100, 0, 0, 0);             // BEQ
    run_instr(4'b0001, MAX_WAIT, 0, 0);      // ready on the last allowed cycle
    run_instr(4'b0000, MAX_WAIT + 1, 0, 0);  // fetch timeout -> ERROR
    run_instr(4'b0011, 0, MAX_WAIT, 0);
    run_instr(4'b0011, 0, MAX_WAIT + 1, 0);  // store timeout
    run_instr(4'b0010, 0, MAX_WAIT + 1, 0);  // load timeout
    run_instr(4'b0101, 1, 0, 0);             // J
    run_instr(4'b1010, 0, 0, 0);             // undefined -> NOP
    run_instr(4'b1111, 0, 0, 100);           // HALT held 100 cycles

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      logic [3:0] opc;
      int sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1: opc = 4'b0000;
        2:    opc = 4'b0001;
        3:    opc = 4'b0010;
        4:    opc = 4'b0011;
        5:    opc = 4'b0100;
        6:    opc = 4'b0101;
        7:    opc = (($urandom % 4) == 0) ? 4'b1111 : 4'b0000;
        default: opc = 4'($urandom_range(6, 14));
      endcase
      run_instr(opc, pick_waits(), pick_waits(), 5);
    end

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
